lb2apb: RTL and testbench



---
 rtl/lb2apb.sv | 201 ++++++++++++++++++++
 tb/tb_lb2apb.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/lb2apb.sv
// Local-bus to APB4 master bridge: one write or read in flight, write wins on collision.
// Optional ACCESS-phase watchdog enabled by defining LB2APB_TIMEOUT_EN.
module lb2apb #(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int STRB_W         = DATA_W / 8,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [STRB_W-1:0] wstrb,
   input  logic              wen,
   output logic              wready,
   input  logic [ADDR_W-1:0] raddr,
   input  logic              ren,
   output logic [DATA_W-1:0] rdata,
   output logic              rvalid,
   output logic              err,
   output logic              psel,
   output logic              penable,
   output logic              pwrite,
   output logic [ADDR_W-1:0] paddr,
   output logic [DATA_W-1:0] pwdata,
   output logic [STRB_W-1:0] pstrb,
   output logic [2:0]        pprot,
   input  logic [DATA_W-1:0] prdata,
   input  logic              pready,
   input  logic              pslverr
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t            state_q,   state_d;
   logic              psel_q,    psel_d;
   logic              penable_q, penable_d;
   logic              pwrite_q,  pwrite_d;
   logic [ADDR_W-1:0] paddr_q,   paddr_d;
   logic [DATA_W-1:0] pwdata_q,  pwdata_d;
   logic [STRB_W-1:0] pstrb_q,   pstrb_d;
   logic              wready_q,  wready_d;
   logic              rvalid_q,  rvalid_d;
   logic              err_q,     err_d;
   logic [DATA_W-1:0] rdata_q,   rdata_d;
   logic              tmo_hit_s;

`ifdef LB2APB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

   logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

   // Watchdog: cleared entering ACCESS, counts stalled ACCESS cycles, saturates
   always_comb begin
      tmo_cnt_d = tmo_cnt_q;
      tmo_hit_s = 1'b0;
      if (state_q == SETUP) begin
         tmo_cnt_d = '0;
      end else if ((state_q == ACCESS) && !pready) begin
         if (tmo_cnt_q != CNT_MAX) begin
            tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
         end else begin
            tmo_cnt_d = tmo_cnt_q;
         end
         tmo_hit_s = (tmo_cnt_d == CNT_MAX);
      end else begin
         tmo_cnt_d = tmo_cnt_q;
      end
   end

   // Watchdog counter register
   always_ff @(posedge clk) begin
      if (rst) begin
         tmo_cnt_q <= '0;
      end else begin
         tmo_cnt_q <= tmo_cnt_d;
      end
   end
`else
   assign tmo_hit_s = 1'b0;
`endif

   // Next-state and registered-output computation
   always_comb begin
      state_d   = state_q;
      psel_d    = psel_q;
      penable_d = penable_q;
      pwrite_d  = pwrite_q;
      paddr_d   = paddr_q;
      pwdata_d  = pwdata_q;
      pstrb_d   = pstrb_q;
      wready_d  = 1'b0;
      rvalid_d  = 1'b0;
      err_d     = 1'b0;
      rdata_d   = '0;
      case (state_q)
         IDLE: begin
            if (wen) begin
               paddr_d   = waddr;
               pwdata_d  = wdata;
               pstrb_d   = wstrb;
               pwrite_d  = 1'b1;
               psel_d    = 1'b1;
               penable_d = 1'b0;
               state_d   = SETUP;
            end else if (ren) begin
               paddr_d   = raddr;
               pstrb_d   = '0;
               pwrite_d  = 1'b0;
               psel_d    = 1'b1;
               penable_d = 1'b0;
               state_d   = SETUP;
            end else begin
               state_d   = IDLE;
            end
         end
         SETUP: begin
            penable_d = 1'b1;
            state_d   = ACCESS;
         end
         ACCESS: begin
            if (pready) begin
               psel_d    = 1'b0;
               penable_d = 1'b0;
               err_d     = pslverr;
               wready_d  = pwrite_q;
               rvalid_d  = ~pwrite_q;
               rdata_d   = pwrite_q ? '0 : prdata;
               state_d   = DONE;
            end else if (tmo_hit_s) begin
               // Abandoned transfer completes with an error and no data
               psel_d    = 1'b0;
               penable_d = 1'b0;
               err_d     = 1'b1;
               wready_d  = pwrite_q;
               rvalid_d  = ~pwrite_q;
               rdata_d   = '0;
               state_d   = DONE;
            end else begin
               state_d   = ACCESS;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            psel_d    = 1'b0;
            penable_d = 1'b0;
            state_d   = IDLE;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         psel_q    <= 1'b0;
         penable_q <= 1'b0;
         pwrite_q  <= 1'b0;
         paddr_q   <= '0;
         pwdata_q  <= '0;
         pstrb_q   <= '0;
         wready_q  <= 1'b0;
         rvalid_q  <= 1'b0;
         err_q     <= 1'b0;
         rdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         psel_q    <= psel_d;
         penable_q <= penable_d;
         pwrite_q  <= pwrite_d;
         paddr_q   <= paddr_d;
         pwdata_q  <= pwdata_d;
         pstrb_q   <= pstrb_d;
         wready_q  <= wready_d;
         rvalid_q  <= rvalid_d;
         err_q     <= err_d;
         rdata_q   <= rdata_d;
      end
   end

   assign psel    = psel_q;
   assign penable = penable_q;
   assign pwrite  = pwrite_q;
   assign paddr   = paddr_q;
   assign pwdata  = pwdata_q;
   assign pstrb   = pstrb_q;
   assign pprot   = 3'b000;
   assign wready  = wready_q;
   assign rvalid  = rvalid_q;
   assign err     = err_q;
   assign rdata   = rdata_q;

endmodule

// File: tb/tb_lb2apb.sv
// Bench for lb2apb: vector table through a scoreboard, behavioural APB slave, corner sequences.
module tb_lb2apb;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] waddr = 32'h0, wdata = 32'h0, raddr = 32'h0;
   logic [3:0]  wstrb = 4'h0;
   logic        wen = 1'b0, ren = 1'b0;
   logic        wready, rvalid, err, psel, penable, pwrite;
   logic [31:0] rdata, paddr, pwdata;
   logic [3:0]  pstrb;
   logic [2:0]  pprot;
   logic [31:0] prdata = 32'h0;
   logic        pready = 1'b0, pslverr = 1'b0;

   lb2apb #(.ADDR_W(32), .DATA_W(32), .STRB_W(4), .TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .rst(rst),
      .waddr(waddr), .wdata(wdata), .wstrb(wstrb), .wen(wen), .wready(wready),
      .raddr(raddr), .ren(ren), .rdata(rdata), .rvalid(rvalid), .err(err),
      .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
      .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
      .prdata(prdata), .pready(pready), .pslverr(pslverr)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        is_write;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      int          waits;
      logic        slverr;
      logic [31:0] exp_rdata;
      logic        exp_err;
      int          exp_lat;
   } vec_t;

   typedef struct {
      int          waits;
      logic [31:0] rdata;
      logic        err;
   } slv_t;

   typedef struct {
      logic        is_write;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [31:0] rdata;
      logic        err;
      int          lat;
      int          start;
   } exp_t;

   exp_t exp_q[$];
   slv_t slv_q[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // APB slave: pops one config per SETUP, inserts the configured wait states
   slv_t cur = '{0, 32'h0, 1'b0};
   int   acc = 0;
   always @(negedge clk) begin
      if (rst || !psel) begin
         pready = 1'b0; pslverr = 1'b0; acc = 0; prdata = 32'h0BAD0BAD;
      end else if (!penable) begin
         if (slv_q.size() > 0) cur = slv_q.pop_front();
         pready = 1'b0; pslverr = 1'b0; acc = 0; prdata = 32'h0BAD0BAD;
      end else begin
         acc++;
         pready  = (acc > cur.waits);
         pslverr = pready & cur.err;
         prdata  = pready ? cur.rdata : 32'h0BAD0BAD;
      end
   end

   // Monitor: APB fields against the pending expectation, completions popped from the scoreboard
   exp_t e;
   always @(negedge clk) begin
      if (!rst) begin
         if (!rvalid) chk("rdata_idle_zero", rdata, 0);
         if (!wready && !rvalid) chk("err_idle_zero", err, 0);
         if (psel && exp_q.size() > 0) begin
            chk("apb_paddr", paddr, exp_q[0].addr);
            chk("apb_pwrite", pwrite, exp_q[0].is_write);
            chk("apb_pstrb", pstrb, exp_q[0].strb);
            if (exp_q[0].is_write) chk("apb_pwdata", pwdata, exp_q[0].data);
         end
         if (wready || rvalid) begin
            if (exp_q.size() == 0) begin
               chk("spurious_done", {wready, rvalid}, 0);
            end else begin
               e = exp_q.pop_front();
               chk("done_kind", {wready, rvalid}, e.is_write ? 2'b10 : 2'b01);
               chk("done_rdata", rdata, e.rdata);
               chk("done_err", err, e.err);
               chk("done_latency", cyc - e.start, e.lat);
               chk("done_apb_idle", {psel, penable}, 0);
            end
         end
      end
   end

   // Requester: holds each request until its completion pulse, then drops it
   task automatic run_req(input logic do_w, input logic do_r, input logic [31:0] wa,
                          input logic [31:0] wd, input logic [3:0] ws, input logic [31:0] ra,
                          input bit scramble, input int budget, output bit timed_out);
      int n;
      bit wdone, rdone;
      waddr = wa; wdata = wd; wstrb = ws; raddr = ra;
      wen = do_w; ren = do_r;
      wdone = !do_w; rdone = !do_r; n = 0; timed_out = 1'b0;
      while (!(wdone && rdone)) begin
         @(negedge clk);
         n++;
         if (wready) begin wdone = 1'b1; wen = 1'b0; end
         if (rvalid) begin rdone = 1'b1; ren = 1'b0; end
         if (scramble && n >= 2) begin
            waddr = ~wa ^ n; wdata = ~wd; wstrb = ~ws; raddr = ~ra ^ n;
         end
         if (n >= budget) begin timed_out = 1'b1; break; end
      end
      wen = 1'b0; ren = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL global_watchdog: got stuck want finish");
      $fatal(1, "watchdog");
   end

   localparam int NV = 7;
   vec_t tbl [NV];
   vec_t v;
   bit   to;

   initial begin
      tbl[0] = '{1'b1, 32'h80000004, 32'hdeadbeef, 4'hF, 0, 1'b0, 32'h0,        1'b0, 3};
      tbl[1] = '{1'b1, 32'h0000000C, 32'hcafebabe, 4'h6, 5, 1'b0, 32'h0,        1'b0, 8};
      tbl[2] = '{1'b0, 32'h00000014, 32'hc0debabe, 4'hF, 0, 1'b0, 32'hc0debabe, 1'b0, 3};
      tbl[3] = '{1'b0, 32'h00000008, 32'hdeadbeef, 4'hF, 5, 1'b0, 32'hdeadbeef, 1'b0, 8};
      tbl[4] = '{1'b0, 32'h00000020, 32'h12345678, 4'hF, 0, 1'b1, 32'h12345678, 1'b1, 3};
      tbl[5] = '{1'b1, 32'h00000030, 32'h0000a5a5, 4'h3, 2, 1'b1, 32'h0,        1'b1, 5};
      tbl[6] = '{1'b0, 32'h00000040, 32'hffffffff, 4'hF, 1, 1'b0, 32'hffffffff, 1'b0, 4};

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_ctrl", {psel, penable, pwrite, wready, rvalid, err}, 0);
      chk("reset_paddr", paddr, 0);
      chk("reset_pwdata", pwdata, 0);
      chk("reset_pstrb", pstrb, 0);
      chk("reset_rdata", rdata, 0);
      chk("reset_pprot", pprot, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < NV; i++) begin
         v = tbl[i];
         slv_q.push_back('{v.waits, v.data, v.slverr});
         exp_q.push_back('{v.is_write, v.addr, v.data, v.is_write ? v.strb : 4'h0,
                           v.exp_rdata, v.exp_err, v.exp_lat, cyc});
         run_req(v.is_write, !v.is_write, v.addr, v.data, v.strb, v.addr, 1'b1, 100, to);
         chk($sformatf("vec%0d_timeout", i), to, 0);
      end

      // Simultaneous write and read: write first, read issued on the IDLE after DONE
      slv_q.push_back('{0, 32'h0, 1'b0});
      slv_q.push_back('{0, 32'h11223344, 1'b0});
      exp_q.push_back('{1'b1, 32'h10, 32'h0acce55, 4'hF, 32'h0, 1'b0, 3, cyc});
      exp_q.push_back('{1'b0, 32'h14, 32'h0, 4'h0, 32'h11223344, 1'b0, 7, cyc});
      run_req(1'b1, 1'b1, 32'h10, 32'h0acce55, 4'hF, 32'h14, 1'b0, 100, to);
      chk("collide_timeout", to, 0);

`ifdef LB2APB_TIMEOUT_EN
      slv_q.push_back('{1000, 32'h5a5a5a5a, 1'b0});
      exp_q.push_back('{1'b0, 32'h50, 32'h0, 4'h0, 32'h0, 1'b1, 18, cyc});
      run_req(1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 32'h50, 1'b0, 100, to);
      chk("watchdog_timeout", to, 0);
`endif

      // Stalled read aborted by reset mid-ACCESS
      slv_q.push_back('{1000, 32'h55555555, 1'b0});
      raddr = 32'h60; ren = 1'b1;
      for (int k = 0; k < 20 && !(psel && penable); k++) @(negedge clk);
      chk("abort_reached_access", psel && penable, 1);
`ifdef LB2APB_TIMEOUT_EN
      repeat (3) @(negedge clk);
`else
      repeat (30) @(negedge clk);
`endif
      chk("stuck_psel_held", {psel, penable}, 2'b11);
      @(posedge clk); #1;
      rst = 1'b1; ren = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("abort_ctrl", {psel, penable, pwrite, wready, rvalid, err}, 0);
      chk("abort_paddr", paddr, 0);
      chk("abort_pwdata", pwdata, 0);
      chk("abort_rdata", rdata, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (6) @(negedge clk);
      @(posedge clk); #1;

      // Recovery after reset
      slv_q.push_back('{1, 32'h0, 1'b0});
      exp_q.push_back('{1'b1, 32'h70, 32'h01020304, 4'h9, 32'h0, 1'b0, 4, cyc});
      run_req(1'b1, 1'b0, 32'h70, 32'h01020304, 4'h9, 32'h0, 1'b1, 100, to);
      chk("recover_timeout", to, 0);

      repeat (3) @(negedge clk);
      chk("scoreboard_drained", exp_q.size(), 0);
      chk("slave_cfg_drained", slv_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
